// File: rtl/cpu_bus_if.sv
// Byte-wide memory/IO bus between the core and its memory system.
// The core holds address, r/w and data_out steady until ready is sampled high.
interface cpu_bus_if #(parameter int AW = 16);
  logic [AW-1:0] adress_bus;
  logic [7:0]    data_in;
  logic [7:0]    data_out;
  logic          r;
  logic          w;
  logic          ready;

  modport master (output adress_bus, data_out, r, w, input data_in, ready);
  modport slave  (input adress_bus, data_out, r, w, output data_in, ready);
endinterface

// File: rtl/cpu_core_p.sv
// Small accumulator-less CPU: 2-byte instructions, DW-wide register file,
// ALU/branch/system ops plus byte-serial LD/ST into an IO window.
module cpu_core_p #(
  parameter int          DW       = 8,
  parameter int          NREG     = 16,
  parameter int          AW       = 16,
  parameter logic [15:0] RESET_PC = 16'h2000,
  parameter logic [15:0] IO_BASE  = 16'hFF00
) (
  input  logic      clk,
  input  logic      reset,
  cpu_bus_if.master bus,
  output logic      halt
);
  typedef enum logic [2:0] {FETCH0, FETCH1, EXEC, MEM, HALTED} state_t;

  state_t        state, nxt_state;
  logic [AW-1:0] pc, nxt_pc, ipc, nxt_ipc, addr, nxt_addr;
  logic [7:0]    ir0, nxt_ir0, ir1, nxt_ir1, dout, nxt_dout, lo, nxt_lo;
  logic          rq, nxt_rq, wq, nxt_wq, mb, nxt_mb, hlt, nxt_hlt;
  logic          c_f, z_f, n_f, v_f, nxt_c, nxt_z, nxt_n, nxt_v;
  logic [DW-1:0] regs [NREG];
  logic          we;
  logic [DW-1:0] wd, res;

  logic [3:0]    op, rd;
  logic [DW-1:0] a, b;
  logic [DW:0]   sum, diff;
  logic [15:0]   ld16, st16;
  logic [AW-1:0] io_addr, off;
  logic          take;

  assign bus.adress_bus = addr;
  assign bus.r          = rq;
  assign bus.w          = wq;
  assign bus.data_out   = dout;
  assign halt           = hlt;

  assign op      = ir0[7:4];
  assign rd      = ir0[3:0];
  assign a       = (32'(rd) < NREG) ? regs[rd] : '0;
  assign b       = op[3] ? ((32'(ir1[3:0]) < NREG) ? regs[ir1[3:0]] : '0) : DW'(ir1);
  assign sum     = {1'b0, a} + {1'b0, b};
  assign diff    = {1'b0, a} - {1'b0, b};
  assign st16    = 16'(a);
  assign ld16    = (DW == 16) ? {bus.data_in, lo} : {8'h00, bus.data_in};
  assign io_addr = AW'(IO_BASE) + AW'(ir1[6:0]);
  assign off     = {{(AW-8){ir1[7]}}, ir1};

  always_comb begin
    case (rd)
      4'h0: take = z_f;
      4'h1: take = ~z_f;
      4'h2: take = c_f;
      4'h3: take = ~c_f;
      4'h4: take = n_f;
      4'h5: take = ~n_f;
      4'h6: take = v_f;
      4'h7: take = ~v_f;
      4'h8: take = n_f ^ v_f;
      4'h9: take = ~(n_f ^ v_f);
      4'hA: take = 1'b1;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    nxt_state = state; nxt_pc = pc; nxt_ipc = ipc; nxt_addr = addr;
    nxt_ir0 = ir0; nxt_ir1 = ir1; nxt_dout = dout; nxt_lo = lo;
    nxt_rq = rq; nxt_wq = wq; nxt_mb = mb; nxt_hlt = hlt;
    nxt_c = c_f; nxt_z = z_f; nxt_n = n_f; nxt_v = v_f;
    we = 1'b0; res = a; wd = '0;
    case (state)
      FETCH0: begin
        // r low here only right after reset: issue the first fetch
        if (!rq) begin
          nxt_rq = 1'b1; nxt_addr = pc;
        end else if (bus.ready) begin
          nxt_ir0 = bus.data_in; nxt_ipc = pc;
          nxt_pc = pc + 1'b1; nxt_addr = pc + 1'b1;
          nxt_state = FETCH1;
        end
      end
      FETCH1: if (bus.ready) begin
        nxt_ir1 = bus.data_in; nxt_pc = pc + 1'b1;
        nxt_rq = 1'b0; nxt_state = EXEC;
      end
      EXEC: begin
        nxt_state = FETCH0; nxt_rq = 1'b1; nxt_addr = pc;
        case (op)
          4'h7: if (take) begin
            nxt_pc = ipc + off; nxt_addr = ipc + off;
          end
          4'hE: begin
            nxt_state = MEM; nxt_addr = io_addr; nxt_mb = 1'b0;
            nxt_rq = ~ir1[7]; nxt_wq = ir1[7]; nxt_dout = st16[7:0];
          end
          4'hF: case (ir1)
            8'h01: begin nxt_state = HALTED; nxt_rq = 1'b0; nxt_hlt = 1'b1; end
            8'h02: nxt_c = 1'b0;
            8'h03: begin nxt_c = 1'b0; nxt_z = 1'b0; nxt_n = 1'b0; nxt_v = 1'b0; end
            default: ;
          endcase
          default: begin
            case (op[2:0])
              3'd0: begin
                res = sum[DW-1:0]; nxt_c = sum[DW];
                nxt_v = (a[DW-1] == b[DW-1]) && (res[DW-1] != a[DW-1]);
              end
              3'd1, 3'd6: begin
                res = diff[DW-1:0]; nxt_c = diff[DW];
                nxt_v = (a[DW-1] != b[DW-1]) && (res[DW-1] != a[DW-1]);
              end
              3'd2: begin res = a & b; nxt_v = 1'b0; end
              3'd3: begin res = a | b; nxt_v = 1'b0; end
              3'd4: begin res = a ^ b; nxt_v = 1'b0; end
              default: res = b;
            endcase
            if (op[2:0] != 3'd5) begin
              nxt_z = (res == '0); nxt_n = res[DW-1];
            end
            we = (op[2:0] != 3'd6);
            wd = res;
          end
        endcase
      end
      MEM: if (bus.ready) begin
        // 16-bit transfers go low byte first, then high byte at addr+1
        if (DW == 16 && !mb) begin
          nxt_mb = 1'b1; nxt_lo = bus.data_in;
          nxt_addr = addr + 1'b1; nxt_dout = st16[15:8];
        end else begin
          we = rq; wd = ld16[DW-1:0];
          nxt_rq = 1'b1; nxt_wq = 1'b0; nxt_addr = pc; nxt_state = FETCH0;
        end
      end
      HALTED: ;
      default: nxt_state = FETCH0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH0; pc <= AW'(RESET_PC); ipc <= '0; addr <= '0;
      ir0 <= '0; ir1 <= '0; dout <= '0; lo <= '0;
      rq <= 1'b0; wq <= 1'b0; mb <= 1'b0; hlt <= 1'b0;
      c_f <= 1'b0; z_f <= 1'b0; n_f <= 1'b0; v_f <= 1'b0;
    end else begin
      state <= nxt_state; pc <= nxt_pc; ipc <= nxt_ipc; addr <= nxt_addr;
      ir0 <= nxt_ir0; ir1 <= nxt_ir1; dout <= nxt_dout; lo <= nxt_lo;
      rq <= nxt_rq; wq <= nxt_wq; mb <= nxt_mb; hlt <= nxt_hlt;
      c_f <= nxt_c; z_f <= nxt_z; n_f <= nxt_n; v_f <= nxt_v;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && 32'(rd) < NREG) begin
      regs[rd] <= wd;
    end
  end
endmodule

// File: tb/tb_cpu_core_p.sv
// Directed checks of cpu_core_p: one DW=8 and one DW=16 core, each with its
// own program memory and IO window at FF00.
module tb_cpu_core_p;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rdy8 = 1'b1;
  logic rdy16 = 1'b1;
  logic halt8, halt16;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [7:0]  prog8 [65536];
  logic [7:0]  prog16 [65536];
  bit   [7:0]  io8 [256];
  bit   [7:0]  io16 [256];
  logic [15:0] wl_a [$];
  logic [7:0]  wl_d [$];
  logic        wl_r [$];

  cpu_bus_if #(.AW(16)) b8 ();
  cpu_bus_if #(.AW(16)) b16 ();

  cpu_core_p #(.DW(8))  u8  (.clk(clk), .reset(reset), .bus(b8.master),  .halt(halt8));
  cpu_core_p #(.DW(16)) u16 (.clk(clk), .reset(reset), .bus(b16.master), .halt(halt16));

  always #5 clk = ~clk;

  assign b8.ready    = rdy8;
  assign b16.ready   = rdy16;
  assign b8.data_in  = (b8.adress_bus[15:8] == 8'hFF)  ? io8[b8.adress_bus[7:0]]   : prog8[b8.adress_bus];
  assign b16.data_in = (b16.adress_bus[15:8] == 8'hFF) ? io16[b16.adress_bus[7:0]] : prog16[b16.adress_bus];

  always @(posedge clk) begin
    if (b8.w && b8.ready) io8[b8.adress_bus[7:0]] <= b8.data_out;
    if (b16.w && b16.ready) begin
      io16[b16.adress_bus[7:0]] <= b16.data_out;
      wl_a.push_back(b16.adress_bus);
      wl_d.push_back(b16.data_out);
      wl_r.push_back(b16.r);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put(input bit sel16, input logic [15:0] a, input logic [7:0] b0, input logic [7:0] b1);
    if (sel16) begin prog16[a] = b0; prog16[a + 16'd1] = b1; end
    else       begin prog8[a]  = b0; prog8[a + 16'd1]  = b1; end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_halt(input bit sel16, input int exp, input string tag);
    int n;
    bit h;
    n = 0; h = 1'b0;
    while (n < 200 && !h) begin
      @(posedge clk); #1;
      n++;
      h = sel16 ? halt16 : halt8;
    end
    chk(tag, n, exp);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin prog8[i] = 8'h00; prog16[i] = 8'h00; end

    // MOV R1,#FF ; ADD R1,#01 ; HLT
    put(0, 16'h2000, 8'h51, 8'hFF); put(0, 16'h2002, 8'h01, 8'h01); put(0, 16'h2004, 8'hF0, 8'h01);

    #2 reset = 1'b0;
    #1;
    chk("rst_r",    b8.r, 0);
    chk("rst_w",    b8.w, 0);
    chk("rst_addr", b8.adress_bus, 16'h0000);
    chk("rst_dout", b8.data_out, 8'h00);
    chk("rst_halt", halt8, 0);
    chk("rst_pc",   u8.pc, 16'h2000);
    chk("rst_reg",  u8.regs[1], 0);
    chk("rst_r16",  b16.r, 0);
    @(negedge clk); reset = 1'b1;

    wait_halt(0, 10, "t1_cycles");
    chk("t1_r1", u8.regs[1], 8'h00);
    chk("t1_c",  u8.c_f, 1);
    chk("t1_z",  u8.z_f, 1);
    chk("t1_v",  u8.v_f, 0);
    chk("t1_n",  u8.n_f, 0);
    chk("t1_halt_r", b8.r, 0);
    chk("t1_halt_w", b8.w, 0);

    // first fetch stalled by ready low
    rdy8 = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("stall_addr", b8.adress_bus, 16'h2000);
      chk("stall_r",    b8.r, 1);
      chk("stall_pc",   u8.pc, 16'h2000);
    end
    rdy8 = 1'b1;
    step(1);
    chk("stall_next_addr", b8.adress_bus, 16'h2001);
    chk("stall_next_pc",   u8.pc, 16'h2001);

    // SUB R0,#01 ; AND R0,#80 ; CLC ; HLT
    put(0, 16'h2000, 8'h10, 8'h01); put(0, 16'h2002, 8'h20, 8'h80);
    put(0, 16'h2004, 8'hF0, 8'h02); put(0, 16'h2006, 8'hF0, 8'h01);
    do_reset();
    wait_halt(0, 13, "t7_cycles");
    chk("t7_r0", u8.regs[0], 8'h80);
    chk("t7_n",  u8.n_f, 1);
    chk("t7_z",  u8.z_f, 0);
    chk("t7_c",  u8.c_f, 0);
    chk("t7_v",  u8.v_f, 0);

    // SUB R0,#01 ; BRCS -2
    put(0, 16'h2000, 8'h10, 8'h01); put(0, 16'h2002, 8'h72, 8'hFE);
    do_reset();
    step(4);
    chk("br_fetch2", b8.adress_bus, 16'h2002);
    step(3);
    chk("br_taken_addr", b8.adress_bus, 16'h2000);
    chk("br_taken_pc",   u8.pc, 16'h2000);
    chk("br_taken_r",    b8.r, 1);
    chk("br_c",          u8.c_f, 1);
    chk("br_r0",         u8.regs[0], 8'hFF);
    put(0, 16'h2002, 8'h73, 8'hFE);
    do_reset();
    step(7);
    chk("br_not_taken", b8.adress_bus, 16'h2004);

    // MOV R1,#AB ; ST R1 -> FF00 ; HLT
    put(0, 16'h2000, 8'h51, 8'hAB); put(0, 16'h2002, 8'hE1, 8'h80); put(0, 16'h2004, 8'hF0, 8'h01);
    do_reset();
    wait_halt(0, 11, "st8_cycles");
    chk("st8_mem", io8[0], 8'hAB);

    // DW=16: MOV R2,#7F ; ADD R2,R2 x9 ; CMP R2,#00 ; HLT
    put(1, 16'h2000, 8'h52, 8'h7F);
    for (int i = 0; i < 9; i++) put(1, 16'(16'h2002 + 2 * i), 8'h82, 8'h02);
    put(1, 16'h2014, 8'h62, 8'h00); put(1, 16'h2016, 8'hF0, 8'h01);
    do_reset();
    wait_halt(1, 37, "t2_cycles");
    chk("t2_r2", u16.regs[2], 16'hFE00);
    chk("t2_z",  u16.z_f, 0);
    chk("t2_c",  u16.c_f, 0);
    chk("t2_n",  u16.n_f, 1);

    // MOV R3,#12 ; ADD R3,R3 x8 ; ADD R3,#34 ; ST R3 FF05 ; LD R4 FF05 ; HLT
    put(1, 16'h2000, 8'h53, 8'h12);
    for (int i = 0; i < 8; i++) put(1, 16'(16'h2002 + 2 * i), 8'h83, 8'h03);
    put(1, 16'h2012, 8'h03, 8'h34); put(1, 16'h2014, 8'hE3, 8'h85);
    put(1, 16'h2016, 8'hE4, 8'h05); put(1, 16'h2018, 8'hF0, 8'h01);
    do_reset();
    wait_halt(1, 44, "t5_cycles");
    chk("t5_r3", u16.regs[3], 16'h1234);
    chk("t5_r4", u16.regs[4], 16'h1234);
    chk("t5_nwr", wl_a.size(), 2);
    if (wl_a.size() == 2) begin
      chk("t5_wa0", wl_a[0], 16'hFF05);
      chk("t5_wd0", wl_d[0], 8'h34);
      chk("t5_wr0", wl_r[0], 0);
      chk("t5_wa1", wl_a[1], 16'hFF06);
      chk("t5_wd1", wl_d[1], 8'h12);
      chk("t5_wr1", wl_r[1], 0);
    end

    // halted, then async reset mid-cycle
    chk("t6_halt", halt16, 1);
    chk("t6_r",    b16.r, 0);
    chk("t6_w",    b16.w, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("t6_halt_clr", halt16, 0);
    chk("t6_reg",      u16.regs[4], 0);
    chk("t6_pc",       u16.pc, 16'h2000);
    @(negedge clk); reset = 1'b1;
    step(1);
    chk("t6_fetch_addr", b16.adress_bus, 16'h2000);
    chk("t6_fetch_r",    b16.r, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
